// File: rtl/div_pkg.sv
// Shared types and constants for the EX-stage multi-cycle divider.
// Contains the FSM state encoding, handshake levels, ALU op codes and the sign-correction helper.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [5:0] DIV_LAST_ITER = 6'd31;

  // Two's-complement negate when en is set, pass through otherwise.
  function automatic logic [REG_BUS-1:0] cond_neg(input logic [REG_BUS-1:0] x, input logic en);
    if (en) begin
      return ~x + 32'd1;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock on operand magnitudes,
// with the signs re-applied when the final {remainder, quotient} is loaded into result_o.
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  div_state_e                state_r, state_nxt_s;
  logic [5:0]                cnt_r, cnt_nxt_s;
  logic [REG_BUS-1:0]        dividend_r, dividend_nxt_s;
  logic [REG_BUS-1:0]        divisor_r, divisor_nxt_s;
  logic [REG_BUS-1:0]        rem_r, rem_nxt_s;
  logic [REG_BUS-1:0]        quot_r, quot_nxt_s;
  logic                      sign1_r, sign1_nxt_s;
  logic                      sign2_r, sign2_nxt_s;
  logic                      signed_r, signed_nxt_s;
  logic [DOUBLE_REG_BUS-1:0] result_r, result_nxt_s;
  logic                      ready_r, ready_nxt_s;

  logic [REG_BUS:0]          shifted_s;
  logic [REG_BUS:0]          diff_s;
  logic                      quot_bit_s;
  logic [REG_BUS-1:0]        rem_step_s;
  logic [REG_BUS-1:0]        quot_step_s;
  logic                      neg_quot_s;
  logic                      neg_rem_s;

  // Single restoring step: the partial remainder never exceeds the divisor, so 32 bits hold it
  // and the 33-bit trial difference's MSB is the borrow.
  always_comb begin
    shifted_s   = {rem_r, dividend_r[REG_BUS-1]};
    diff_s      = shifted_s - {1'b0, divisor_r};
    quot_bit_s  = ~diff_s[REG_BUS];
    rem_step_s  = quot_bit_s ? diff_s[REG_BUS-1:0] : shifted_s[REG_BUS-1:0];
    quot_step_s = {quot_r[REG_BUS-2:0], quot_bit_s};
    neg_quot_s  = signed_r & (sign1_r ^ sign2_r);
    neg_rem_s   = signed_r & sign1_r;
  end

  // Next-state and next-datapath logic; every register holds unless a state says otherwise.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    dividend_nxt_s = dividend_r;
    divisor_nxt_s  = divisor_r;
    rem_nxt_s      = rem_r;
    quot_nxt_s     = quot_r;
    sign1_nxt_s    = sign1_r;
    sign2_nxt_s    = sign2_r;
    signed_nxt_s   = signed_r;
    result_nxt_s   = result_r;
    ready_nxt_s    = ready_r;

    case (state_r)
      DIV_FREE: begin
        result_nxt_s = 64'd0;
        ready_nxt_s  = DIV_RESULT_NOT_READY;
        if ((start_i == DIV_START) && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_nxt_s = DIV_BY_ZERO;
          end else begin
            state_nxt_s    = DIV_ON;
            cnt_nxt_s      = 6'd0;
            dividend_nxt_s = cond_neg(opdata1_i, signed_div_i & opdata1_i[REG_BUS-1]);
            divisor_nxt_s  = cond_neg(opdata2_i, signed_div_i & opdata2_i[REG_BUS-1]);
            rem_nxt_s      = 32'd0;
            quot_nxt_s     = 32'd0;
            sign1_nxt_s    = opdata1_i[REG_BUS-1];
            sign2_nxt_s    = opdata2_i[REG_BUS-1];
            signed_nxt_s   = signed_div_i;
          end
        end else begin
          state_nxt_s = DIV_FREE;
        end
      end

      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_nxt_s = DIV_FREE;
        end else begin
          state_nxt_s  = DIV_END;
          result_nxt_s = 64'd0;
          ready_nxt_s  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_nxt_s = DIV_FREE;
          ready_nxt_s = DIV_RESULT_NOT_READY;
        end else begin
          rem_nxt_s      = rem_step_s;
          quot_nxt_s     = quot_step_s;
          dividend_nxt_s = {dividend_r[REG_BUS-2:0], 1'b0};
          cnt_nxt_s      = cnt_r + 6'd1;
          if (cnt_r == DIV_LAST_ITER) begin
            state_nxt_s  = DIV_END;
            result_nxt_s = {cond_neg(rem_step_s, neg_rem_s), cond_neg(quot_step_s, neg_quot_s)};
            ready_nxt_s  = DIV_RESULT_READY;
          end else begin
            state_nxt_s = DIV_ON;
          end
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_nxt_s  = DIV_FREE;
          result_nxt_s = 64'd0;
          ready_nxt_s  = DIV_RESULT_NOT_READY;
        end else begin
          state_nxt_s = DIV_END;
        end
      end

      default: begin
        state_nxt_s  = DIV_FREE;
        result_nxt_s = 64'd0;
        ready_nxt_s  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // State, datapath and output registers; rst is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= DIV_FREE;
      cnt_r      <= 6'd0;
      dividend_r <= 32'd0;
      divisor_r  <= 32'd0;
      rem_r      <= 32'd0;
      quot_r     <= 32'd0;
      sign1_r    <= 1'b0;
      sign2_r    <= 1'b0;
      signed_r   <= 1'b0;
      result_r   <= 64'd0;
      ready_r    <= DIV_RESULT_NOT_READY;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      dividend_r <= dividend_nxt_s;
      divisor_r  <= divisor_nxt_s;
      rem_r      <= rem_nxt_s;
      quot_r     <= quot_nxt_s;
      sign1_r    <= sign1_nxt_s;
      sign2_r    <= sign2_nxt_s;
      signed_r   <= signed_nxt_s;
      result_r   <= result_nxt_s;
      ready_r    <= ready_nxt_s;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: hand-computed DIV/DIVU vectors, divide-by-zero,
// annul mid-iteration and asynchronous reset, checked with immediate assertions.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks;
  int errors;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point sits 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op, scramble operands after the start edge, count edges until ready_o,
  // then check latency, result, hold while start_i stays high, and clear after it drops.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin
        opdata1_i    = 32'h1234_5678;
        opdata2_i    = 32'h0000_0003;
        signed_div_i = ~sgn;
      end
      if (ready_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp_res);
    tick();
    chk({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
    chk({tag, "_hold_result"}, result_o, exp_res);
    start_i = 1'b0;
    tick();
    chk({tag, "_clr_ready"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_clr_result"}, result_o, 64'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    tick();
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("idle_ready", {63'd0, ready_o}, 64'd0);

    run_op("divu_100_7",   1'b0, 32'd100,       32'd7,         {32'h0000_0002, 32'h0000_000E}, 33);
    run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_op("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run_op("div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 33);
    run_op("div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
    run_op("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         {32'h0000_0000, 32'hFFFF_FFFF}, 33);
    run_op("divu_8m_max",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 33);
    run_op("div_5_0",      1'b1, 32'd5,         32'd0,         64'd0,                           2);

    // Annul at iteration 10: ready_o must never rise, then a fresh DIVU 9/3 completes.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready_o !== 1'b0) break;
    end
    chk("annul_no_ready", {63'd0, ready_o}, 64'd0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0000_0000, 32'h0000_0003}, 33);

    // Annul together with start in DivFree is no start.
    opdata1_i = 32'd50;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    tick();
    tick();
    tick();
    chk("annul_at_start", {63'd0, ready_o}, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Asynchronous reset mid-DivOn.
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_on_ready", {63'd0, ready_o}, 64'd0);
    chk("arst_on_result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("post_reset_idle_ready", {63'd0, ready_o}, 64'd0);
    chk("post_reset_idle_result", result_o, 64'd0);

    // Asynchronous reset while a result is held in DivEnd must clear it without a clock edge.
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    for (int i = 0; i < 33; i++) tick();
    chk("end_ready", {63'd0, ready_o}, 64'd1);
    chk("end_result", result_o, {32'h0000_0002, 32'h0000_000F});
    #2;
    rst = 1'b0;
    #1;
    chk("arst_end_ready", {63'd0, ready_o}, 64'd0);
    chk("arst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("final_idle_ready", {63'd0, ready_o}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX starts an operation with a request/acknowledge handshake, holds the pipeline while the divider iterates, and writes `result_o` to HI/LO through its existing `whilo_o`/`hi_o`/`lo_o` path. Radix-2 restoring division, one quotient bit per clock; signed operation by magnitude division plus sign correction.

## Interface
Parameters: none; widths use `RegBus` (32) and `DoubleRegBus` (64) from `Defines.v`.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend (rs)
- opdata2_i  in  32  divisor (rt)
- start_i  in  1  request; level held by EX until it sees `ready_o`
- annul_i  in  1  abort current operation (flush/exception)
- result_o  out  64  {remainder, quotient}: [63:32] → HI, [31:0] → LO
- ready_o  out  1  result valid

## Operation
- States (2-bit, registered): DivFree, DivByZero, DivOn, DivEnd.
- Reset (rst = 0, any state, any time): state DivFree, counter 0, result_o = 0, ready_o = 0, internal datapath registers 0.
- DivFree: if start_i = 1 and annul_i = 0:
  - divisor = 0 → DivByZero;
  - else latch |opdata1_i|, |opdata2_i| (two's-complement negate when signed_div_i = 1 and bit 31 set), latch signs and signed_div_i, counter 0 → DivOn.
  - Otherwise stay; ready_o = 0, result_o = 0.
- DivByZero: if annul_i = 1 → DivFree; else result_o = 0, ready_o = 1 → DivEnd.
- DivOn: if annul_i = 1 → DivFree (ready_o stays 0). Else one iteration per cycle:
  - shift the 33-bit partial remainder left by one, bringing in the next dividend bit (MSB first);
  - trial-subtract the divisor; if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0;
  - counter += 1.
  - On the iteration with counter = 31 → DivEnd, loading result_o and setting ready_o = 1.
- Sign correction, applied when loading result_o (signed only): negate the quotient if dividend sign ≠ divisor sign; negate the remainder if the dividend is negative. Unsigned: raw magnitudes.
- Overflow case 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0. No trap.
- DivEnd: hold result_o and ready_o. When start_i = 0 → DivFree, clearing ready_o and result_o on the same edge. annul_i is ignored in DivEnd.
- Operand inputs are sampled only at the start edge; later changes have no effect.

## Timing
- Start edge (E0): state leaves DivFree.
- Normal divide: 32 iteration edges E1..E32. ready_o is high from after E32; latency is 33 clocks from E0.
- Divide by zero: ready_o is high after E1.
- EX asserts stall while start_i = 1 and ready_o = 0. It consumes the result in the first cycle ready_o = 1, then drops start_i. ready_o falls one edge later.
- A back-to-back new start is accepted no earlier than the edge after the return to DivFree.
- Annul takes effect on the next edge from DivOn or DivByZero. annul_i together with start_i in DivFree means no start.
- Outputs are registered: no combinational path from inputs to result_o or ready_o.

## Structure
- Add to `Defines.v`: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11; DivResultReady/NotReady, DivStart/Stop, `DoubleRegBus` 63:0; EXE_DIV_OP, EXE_DIVU_OP aluop codes.
- Single flat module `div`. No sub-module; negation uses inline `~x + 1`.
- The EX-side additions (start/annul drive, stall request, HI/LO mux for DIV ops) are separate edits to `ex`, not part of this block.

## Test plan
- Unsigned: DIVU 100 / 7 → after 33 clocks ready_o = 1, result_o = {0x00000002, 0x0000000E}; held until start_i drops, then ready_o = 0 and result_o = 0 one edge later.
- Signed: DIV −7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Edge values: DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divide by zero: DIV 5 / 0 → ready_o = 1 after 2 clocks, result_o = 0.
- Annul: assert annul_i at iteration 10 → DivFree next edge, ready_o never rises. A new start 2 clocks later (DIVU 9 / 3) completes with {0, 3}.
- Reset: drop rst low asynchronously mid-DivOn → ready_o = 0 and result_o = 0 immediately without a clock edge; after release, with start_i = 0, it stays idle.
